adc_seq_ctrl: RTL and testbench
===============================

# adc_seq_ctrl

Conversion sequencer for the board's LTC2308-style serial ADC. It sits between the SCLK clock-enable generator and the audio datapath. It scans a mask of enabled channels round-robin, issuing CONVST, waiting out the conversion, and running a 12-bit full-duplex serial frame that shifts in the previous result while shifting out the next channel's config. Results leave on a valid/ready port tagged with their channel.

## Interface
- `NCH`, 8: number of ADC channels, 1..8.
- `DW`, 12: result width in bits. Also the number of SCLK periods per frame.
- `CONVST_CYCLES`, 2: CONVST high time, in clk_clk cycles.
- `CONV_CYCLES`, 80: conversion wait after CONVST falls (1.6 us at 50 MHz).

Ports:
- `clk_clk`, in, 1: system clock, 50 MHz. Single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: run continuous scanning.
- `ch_mask`, in, NCH: enabled channels. Sampled only at frame start.
- `sclk_rise_ce`, in, 1: one-cycle strobe requesting an SCLK rising edge.
- `sclk_fall_ce`, in, 1: one-cycle strobe requesting an SCLK falling edge. Never coincides with `sclk_rise_ce`.
- `adc_convst`, out, 1: ADC conversion start.
- `adc_sclk`, out, 1: ADC serial clock. Gated, so it toggles only during SHIFT.
- `adc_din`, out, 1: config bits to the ADC.
- `adc_dout`, in, 1: result bits from the ADC.
- `sample_data`, out, DW: result.
- `sample_ch`, out, 3: channel the result belongs to.
- `sample_valid`, out, 1: result available.
- `sample_ready`, in, 1: downstream accepts.
- `busy`, out, 1: high in any state except IDLE.
- `overrun`, out, 1: one-cycle pulse when a result is dropped.

## Operation
- Reset values: all outputs 0. State is IDLE, current channel is 0, `first` flag is 1.
- **IDLE**: leave when `enable` is high and `ch_mask != 0`.
  - Latch the mask.
  - Pick the next channel as the first set bit strictly after the current channel, with wrap-around. Coming out of reset, start the search at channel 0 inclusive.
  - Build cfg6 = {1, ch[0], ch[2], ch[1], 1, 0}. The bits are single-ended, odd/sign, S1, S0, unipolar, no-sleep.
  - Go to CONV.
- **CONV**: hold `adc_convst` high for CONVST_CYCLES, then low. Wait CONV_CYCLES, then go to ALIGN.
- **ALIGN**: wait for `sclk_fall_ce`. On that strobe, drive `adc_din` = cfg6[5], clear the bit counter, and go to SHIFT.
- **SHIFT**:
  - On `sclk_rise_ce`: `adc_sclk` <= 1, shift `adc_dout` into the LSB of the shift register (MSB first), and increment the bit counter.
  - On `sclk_fall_ce`: `adc_sclk` <= 0, then drive the next cfg6 bit. After cfg6[0], drive 0.
  - The fall strobe that follows the DW-th rise strobe moves the block to DONE.
- **DONE**, one cycle:
  - The result belongs to the channel that was configured in the *previous* frame. Publish it unless `first` is set; the first frame after leaving IDLE is discarded. Then clear `first`.
  - If `enable` is high and the mask is nonzero, choose the next channel and go to CONV. Otherwise go to IDLE and set `first`.
- Output register:
  - If `sample_valid` is high and `sample_ready` is low when a new result arrives, the new result is dropped, `overrun` pulses, and the old result is held.
  - On handshake (`valid && ready`), `valid` clears the next cycle unless a new result loads in that same cycle. In that case the new result loads and `valid` stays high.
- When `enable` falls mid-frame, the current frame completes, then the block goes to IDLE.
- Mask changes mid-frame take effect at the next channel selection.

## Timing
- `adc_convst` rises the cycle after the IDLE→CONV or DONE→CONV transition.
- `adc_sclk` and `adc_din` change one clk_clk cycle after their strobe, because they are registered.
- `sample_valid` rises one cycle after DONE. `sample_data` and `sample_ch` are stable while `sample_valid` is high.
- Frame length is CONVST_CYCLES + CONV_CYCLES + ALIGN wait (at most one SCLK period) + DW SCLK periods + 1 cycle.
- An asynchronous reset mid-frame immediately forces `adc_sclk`, `adc_convst`, and `sample_valid` to 0.

## Structure
- Package `adc_seq_pkg` holds:
  - the state enum (IDLE, CONV, ALIGN, SHIFT, DONE);
  - the cfg bit-position constants;
  - a function `mk_cfg(ch)` that returns cfg6.
- One sub-module, `rr_next_ch`: combinational round-robin picker. Inputs are the mask and the current channel; outputs are the next channel and `none`.

## Test plan
- Reset, `enable`=1, `ch_mask`=8'h01, ADC model returns 12'hA5C.
  - The first frame yields no sample.
  - The second frame yields `sample_data`=12'hA5C and `sample_ch`=0.
  - `adc_din` pattern in each frame is 1,0,0,0,1,0 then zeros.
- `ch_mask`=8'b1000_0101, `ready` tied to 1 → `sample_ch` sequence is 0,2,7,0,2. Each result is tagged with the previous frame's channel. `adc_sclk` shows exactly 12 pulses per frame.
- Hold `sample_ready`=0 across two completed frames → `overrun` pulses once and `sample_data` keeps the first value. Releasing `ready` completes one handshake.
- Drop `enable` in mid-SHIFT → the frame finishes (12 SCLK pulses), the block goes to IDLE, `busy`=0, and `adc_convst` stays 0.
- Assert `reset` while in SHIFT → in the same cycle `adc_sclk`, `adc_convst`, and `sample_valid` are all 0. After release, the first frame is again discarded.
- `ch_mask`=0 with `enable`=1 → the block stays in IDLE with no CONVST. Setting the mask to 8'h10 starts scanning on channel 4, with cfg6 = 1,0,1,0,1,0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC conversion sequencer.
// Holds the FSM state encoding and the ADC config-word layout.
package adc_seq_pkg;

  typedef enum logic [2:0] {IDLE, CONV, ALIGN, SHIFT, DONE} state_t;

  localparam int CFG_W   = 6;
  localparam int CFG_SD  = 5;  // single-ended
  localparam int CFG_OS  = 4;  // odd/sign
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;  // unipolar
  localparam int CFG_SLP = 0;  // sleep (kept 0)

  function automatic logic [CFG_W-1:0] mk_cfg(input logic [2:0] ch);
    logic [CFG_W-1:0] c;
    c          = '0;
    c[CFG_SD]  = 1'b1;
    c[CFG_OS]  = ch[0];
    c[CFG_S1]  = ch[2];
    c[CFG_S0]  = ch[1];
    c[CFG_UNI] = 1'b1;
    c[CFG_SLP] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/adc_seq_ctrl_rr.sv
// Round-robin channel picker: first set mask bit strictly after cur, wrapping.
// none is high when the mask is empty.
module rr_next_ch
  import adc_seq_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     cur,
  output logic [2:0]     nxt,
  output logic           none
);

  always_comb begin
    int idx;
    logic [NCH-1:0] sh;
    nxt  = '0;
    none = 1'b1;
    idx  = 0;
    sh   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(cur) + i) % NCH;
      sh  = mask >> idx;
      if (none && sh[0]) begin
        nxt  = 3'(idx);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Conversion sequencer for an LTC2308-style serial ADC: round-robin CONVST,
// conversion wait, 12-bit full-duplex frame, valid/ready result port.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int NCH           = 8,
  parameter int DW            = 12,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80
) (
  input  logic           clk_clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [NCH-1:0] ch_mask,
  input  logic           sclk_rise_ce,
  input  logic           sclk_fall_ce,
  output logic           adc_convst,
  output logic           adc_sclk,
  output logic           adc_din,
  input  logic           adc_dout,
  output logic [DW-1:0]  sample_data,
  output logic [2:0]     sample_ch,
  output logic           sample_valid,
  input  logic           sample_ready,
  output logic           busy,
  output logic           overrun
);

  localparam int CW = $clog2(CONVST_CYCLES + CONV_CYCLES + 1);
  localparam int BW = $clog2(DW + 1);
  localparam logic [CW-1:0] CONVST_LAST = CW'(CONVST_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST   = CW'(CONVST_CYCLES + CONV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2:0]       cur_ch, res_ch, pick_ch, search_from;
  logic             pick_none, can_start, first, from_rst;
  logic [CFG_W-1:0] cfg_sh;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bitcnt;
  logic [DW-1:0]    shreg;
  logic             start_frame, frame_done, load;

  // Out of reset the search starts at channel 0 inclusive.
  assign search_from = from_rst ? 3'(NCH - 1) : cur_ch;

  rr_next_ch #(.NCH(NCH)) u_rr (
    .mask (ch_mask),
    .cur  (search_from),
    .nxt  (pick_ch),
    .none (pick_none)
  );

  assign can_start = enable && !pick_none;
  assign busy      = (state != IDLE);
  assign load      = frame_done && !first;

  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:  if (can_start) begin state_nxt = CONV; start_frame = 1'b1; end
      CONV:  if (cnt == CONV_LAST) state_nxt = ALIGN;
      ALIGN: if (sclk_fall_ce) state_nxt = SHIFT;
      SHIFT: if (sclk_fall_ce && bitcnt == BW'(DW)) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        if (can_start) begin state_nxt = CONV; start_frame = 1'b1; end
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      cur_ch       <= '0;
      res_ch       <= '0;
      first        <= 1'b1;
      from_rst     <= 1'b1;
      cfg_sh       <= '0;
      cnt          <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      adc_convst   <= 1'b0;
      adc_sclk     <= 1'b0;
      adc_din      <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // The frame shifts in the result of the channel configured last frame.
      if (start_frame) begin
        res_ch     <= cur_ch;
        cur_ch     <= pick_ch;
        cfg_sh     <= mk_cfg(pick_ch);
        from_rst   <= 1'b0;
        cnt        <= '0;
        adc_convst <= 1'b1;
      end else if (state == CONV) begin
        cnt <= cnt + 1'b1;
        if (cnt == CONVST_LAST) adc_convst <= 1'b0;
      end

      // cfg_sh drains MSB first; zeros fill in behind the last config bit.
      if (state == ALIGN && sclk_fall_ce) begin
        adc_din <= cfg_sh[CFG_W-1];
        cfg_sh  <= cfg_sh << 1;
        bitcnt  <= '0;
      end else if (state == SHIFT) begin
        if (sclk_rise_ce) begin
          adc_sclk <= 1'b1;
          shreg    <= {shreg[DW-2:0], adc_dout};
          bitcnt   <= bitcnt + 1'b1;
        end
        if (sclk_fall_ce) begin
          adc_sclk <= 1'b0;
          adc_din  <= cfg_sh[CFG_W-1];
          cfg_sh   <= cfg_sh << 1;
        end
      end

      if (frame_done) first <= !can_start;

      // A new result never displaces one still waiting for its handshake.
      if (load && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (load) begin
        sample_data  <= shreg;
        sample_ch    <= res_ch;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Self-checking bench for adc_seq_ctrl: behavioural ADC plus a result/channel
// model checked every cycle, directed scenarios and a randomized soak.
module tb_adc_seq_ctrl;

  localparam int NCH = 8;
  localparam int DW  = 12;
  localparam int CSC = 2;
  localparam int CVC = 80;

  logic           clk_clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic           sclk_rise_ce = 1'b0;
  logic           sclk_fall_ce = 1'b0;
  logic           adc_convst, adc_sclk, adc_din;
  logic           adc_dout = 1'b0;
  logic [DW-1:0]  sample_data;
  logic [2:0]     sample_ch;
  logic           sample_valid;
  logic           sample_ready = 1'b1;
  logic           busy, overrun;

  adc_seq_ctrl #(.NCH(NCH), .DW(DW), .CONVST_CYCLES(CSC), .CONV_CYCLES(CVC)) dut (
    .clk_clk      (clk_clk),
    .reset        (reset),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .sclk_rise_ce (sclk_rise_ce),
    .sclk_fall_ce (sclk_fall_ce),
    .adc_convst   (adc_convst),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always #5 clk_clk = ~clk_clk;

  // SCLK strobe generator; period changes only at a period boundary.
  int half = 4;
  int half_req = 4;
  int ph = 0;
  always @(posedge clk_clk) begin
    #1;
    sclk_rise_ce = (ph == 0);
    sclk_fall_ce = (ph == half);
    if (ph >= 2 * half - 1) begin
      ph   = 0;
      half = half_req;
    end else ph++;
  end

  // Behavioural ADC: converts on CONVST using the config captured last frame,
  // presents MSB first, advances on falling SCLK, captures DIN on rising SCLK.
  logic [DW-1:0] adc_word = '0;
  logic [DW-1:0] fixed_word = '0;
  bit            fixed = 1'b0;
  int            dbit = 0;
  logic [DW-1:0] cap = '0;
  int            ncap = 0;
  logic [2:0]    cfg_ch_last = '0;
  logic [2:0]    conv_tag = '0;
  logic [5:0]    last_cfg6 = '0;
  int            exp_ch = 0;
  bit            exp_pending = 1'b0;

  always @(posedge adc_convst) begin
    conv_tag = cfg_ch_last;
    adc_word = fixed ? fixed_word : DW'($urandom);
    dbit     = DW - 1;
    adc_dout = adc_word[DW-1];
    ncap     = 0;
    cap      = '0;
  end

  always @(negedge adc_sclk) begin
    if (dbit > 0) begin
      dbit--;
      adc_dout = adc_word[dbit];
    end else adc_dout = 1'b0;
  end

  always @(posedge adc_sclk) begin
    logic [5:0] c6, e6;
    logic [2:0] e;
    cap = {cap[DW-2:0], adc_din};
    ncap++;
    if (ncap == 6) begin
      c6          = cap[5:0];
      last_cfg6   = c6;
      cfg_ch_last = {c6[3], c6[2], c6[4]};
      if (exp_pending) begin
        e  = exp_ch[2:0];
        e6 = {1'b1, e[0], e[2], e[1], 1'b1, 1'b0};
        chk(c6 == e6, "cfg_bits", c6, e6);
        exp_pending = 1'b0;
      end
    end
    if (ncap == DW) chk(cap[5:0] == 6'd0, "din_tail", cap[5:0], 0);
  end

  function automatic int rr(input int last, input logic [NCH-1:0] m);
    logic [NCH-1:0] t;
    for (int k = 0; k < NCH; k++) begin
      t = m >> ((last + 1 + k) % NCH);
      if (t[0]) return (last + 1 + k) % NCH;
    end
    return -1;
  endfunction

  // Reference model of the result port, updated once per clock.
  bit             val_e = 1'b0, ov_e = 1'b0;
  logic [DW-1:0]  data_e = '0;
  logic [2:0]     ch_e = '0;
  bit             arr_q = 1'b0, arr_disc = 1'b0, rdy_q = 1'b0, sess_first = 1'b1;
  logic [DW-1:0]  arr_word = '0;
  logic [2:0]     arr_ch = '0;
  bit             sclk_p = 1'b0, cv_p = 1'b0, busy_p = 1'b0, frame_open = 1'b0;
  int             falls = 0, rises = 0, cv_hi = 0, model_last = -1;
  logic [NCH-1:0] mask_p = '0;
  int             arr_cnt = 0, ov_cnt = 0, hs_cnt = 0, cv_rises = 0;
  int             pub_q[$];

  always @(negedge clk_clk) begin
    if (reset) begin
      chk({adc_convst, adc_sclk, adc_din, sample_valid, overrun, busy} == 6'd0, "reset_outputs",
          {adc_convst, adc_sclk, adc_din, sample_valid, overrun, busy}, 0);
      val_e = 0; arr_q = 0; sess_first = 1; model_last = -1; frame_open = 0;
      exp_pending = 0; falls = 0; rises = 0; cv_hi = 0;
      sclk_p = 0; cv_p = 0; busy_p = 0; mask_p = ch_mask; rdy_q = sample_ready;
    end else begin
      ov_e = 0;
      if (arr_q && !arr_disc) begin
        if (val_e && !rdy_q) ov_e = 1;
        else begin val_e = 1; data_e = arr_word; ch_e = arr_ch; end
      end else if (val_e && rdy_q) val_e = 0;
      arr_q = 0;

      chk(sample_valid == val_e, "sample_valid", sample_valid, val_e);
      chk(overrun == ov_e, "overrun", overrun, ov_e);
      if (val_e) begin
        chk(sample_data == data_e, "sample_data", sample_data, data_e);
        chk(sample_ch == ch_e, "sample_ch", sample_ch, ch_e);
      end
      chk(!adc_sclk || busy, "sclk_gated", adc_sclk, 0);
      if (overrun) ov_cnt++;
      if (sample_valid && sample_ready) begin hs_cnt++; pub_q.push_back(int'(sample_ch)); end

      if (adc_convst && !cv_p) begin
        cv_rises++;
        if (frame_open) chk(rises == DW, "sclk_pulses", rises, DW);
        frame_open = 1; rises = 0; falls = 0; cv_hi = 0;
        exp_ch = rr(model_last, mask_p);
        model_last = exp_ch;
        exp_pending = 1;
      end
      if (adc_convst) cv_hi++;
      if (!adc_convst && cv_p) chk(cv_hi == CSC, "convst_width", cv_hi, CSC);
      if (adc_sclk && !sclk_p) rises++;
      if (!adc_sclk && sclk_p) begin
        falls++;
        if (falls == DW) begin
          arr_q = 1; arr_disc = sess_first; sess_first = 0;
          arr_word = adc_word; arr_ch = conv_tag; arr_cnt++;
        end
      end
      if (!busy) begin
        if (busy_p && frame_open) begin
          chk(rises == DW, "sclk_pulses_last", rises, DW);
          frame_open = 0;
        end
        sess_first = 1;
      end
      sclk_p = adc_sclk; cv_p = adc_convst; busy_p = busy;
      mask_p = ch_mask; rdy_q = sample_ready;
    end
  end

  task automatic tick;
    @(posedge clk_clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1; enable = 0; ch_mask = '0; sample_ready = 1;
    repeat (3) tick;
    reset = 0;
    tick;
    pub_q.delete();
  endtask

  task automatic wait_arr(input int n, input string tag);
    int tgt = arr_cnt + n;
    int b = 4000 * n;
    while (arr_cnt < tgt && b > 0) begin tick; b--; end
    chk(arr_cnt >= tgt, {"arrival_", tag}, arr_cnt, tgt);
  endtask

  task automatic wait_idle(input string tag);
    int b = 4000;
    while (busy && b > 0) begin tick; b--; end
    chk(!busy, {"idle_", tag}, busy, 0);
  endtask

  task automatic wait_rises(input int n, input string tag);
    int b = 4000;
    while (!(frame_open && rises >= n && adc_sclk) && b > 0) begin tick; b--; end
    chk(b > 0, {"shift_", tag}, rises, n);
  endtask

  initial begin
    int exp_seq[5] = '{0, 2, 7, 0, 2};
    int cr, hs0;

    // single channel, fixed ADC word
    do_reset;
    fixed = 1; fixed_word = 12'hA5C;
    ch_mask = 8'h01; sample_ready = 1; enable = 1;
    wait_arr(1, "t1a");
    tick;
    chk(sample_valid == 1'b0, "t1_first_discarded", sample_valid, 0);
    chk(last_cfg6 == 6'b100010, "t1_cfg_ch0", last_cfg6, 6'b100010);
    wait_arr(1, "t1b");
    chk(sample_valid == 1'b1, "t1_valid", sample_valid, 1);
    chk(sample_data == 12'hA5C, "t1_data", sample_data, 12'hA5C);
    chk(sample_ch == 3'd0, "t1_ch", sample_ch, 0);

    // round-robin over channels 0, 2, 7
    do_reset;
    fixed = 0;
    ch_mask = 8'b1000_0101; sample_ready = 1; enable = 1;
    wait_arr(6, "t2");
    tick; tick;
    chk(pub_q.size() >= 5, "t2_count", pub_q.size(), 5);
    if (pub_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk(pub_q[i] == exp_seq[i], "t2_ch_seq", pub_q[i], exp_seq[i]);

    // backpressure: one overrun, then one handshake
    do_reset;
    ch_mask = 8'h01; sample_ready = 0; ov_cnt = 0; enable = 1;
    wait_arr(3, "t3");
    tick;
    chk(ov_cnt == 1, "t3_overrun_once", ov_cnt, 1);
    chk(sample_valid == 1'b1, "t3_valid_held", sample_valid, 1);
    hs0 = hs_cnt;
    sample_ready = 1; tick; sample_ready = 0; tick;
    chk(hs_cnt - hs0 == 1, "t3_one_handshake", hs_cnt - hs0, 1);
    chk(sample_valid == 1'b0, "t3_valid_cleared", sample_valid, 0);
    enable = 0;
    wait_idle("t3");

    // enable dropped mid-SHIFT
    do_reset;
    ch_mask = 8'h01; sample_ready = 1; enable = 1;
    wait_rises(3, "t4");
    enable = 0;
    wait_idle("t4");
    chk(rises == 12, "t4_pulses", rises, 12);
    cr = cv_rises;
    repeat (200) tick;
    chk(cv_rises == cr, "t4_no_convst", cv_rises - cr, 0);
    chk(busy == 1'b0, "t4_busy", busy, 0);

    // async reset during SHIFT with a held result
    do_reset;
    ch_mask = 8'h01; sample_ready = 0; enable = 1;
    wait_arr(2, "t5a");
    wait_rises(4, "t5");
    chk(sample_valid == 1'b1, "t5_pre_valid", sample_valid, 1);
    #1 reset = 1;
    #1;
    chk({adc_sclk, adc_convst, sample_valid} == 3'b000, "t5_async_clear",
        {adc_sclk, adc_convst, sample_valid}, 0);
    repeat (2) tick;
    reset = 0; sample_ready = 1;
    wait_arr(1, "t5b");
    chk(sample_valid == 1'b0, "t5_discard", sample_valid, 0);
    wait_arr(1, "t5c");
    chk(sample_valid == 1'b1, "t5_after", sample_valid, 1);

    // empty mask, then channel 4
    do_reset;
    ch_mask = '0; sample_ready = 1; enable = 1;
    cr = cv_rises;
    repeat (300) tick;
    chk(cv_rises == cr, "t6_no_convst", cv_rises - cr, 0);
    chk(busy == 1'b0, "t6_idle", busy, 0);
    ch_mask = 8'h10;
    wait_arr(1, "t6a");
    chk(last_cfg6 == 6'b101010, "t6_cfg_ch4", last_cfg6, 6'b101010);
    wait_arr(1, "t6b");
    chk(sample_valid && sample_ch == 3'd4, "t6_ch4", sample_ch, 4);

    // randomized soak
    do_reset;
    ch_mask = NCH'($urandom); enable = 1;
    for (int i = 0; i < 20000; i++) begin
      tick;
      sample_ready = ($urandom % 4) != 0;
      if ($urandom % 300 == 0) ch_mask = NCH'($urandom);
      if ($urandom % 1500 == 0) enable = !enable;
      if ($urandom % 500 == 0) half_req = $urandom_range(1, 5);
    end
    enable = 0;
    wait_idle("soak");
    repeat (4) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
